interval_timer: RTL
===================

# interval_timer

Programmable down-counting timer that generates the `i_timer` interrupt request consumed by the CPU datapath's interruption logic. The CPU configures it through an 8-bit register port driven from the I/O output ports. It holds the request until the interrupt service finishes, signalled by `s_finish_interr`. A prescaler divides `clk`. A WIDTH-bit counter then counts prescaled ticks in one-shot or periodic mode.

## Interface
Parameters:
- `WIDTH`, 16: main counter and reload width; must be 9..16. Reload is split over two 8-bit registers.
- `PW`, 8: prescaler width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  register write strobe, one cycle per write.
- `addr`  in  2  register select:
  - 0 = RELOAD_LO
  - 1 = RELOAD_HI
  - 2 = PRESC
  - 3 = CTRL
- `wdata`  in  8  write data.
- `rdata`  out  8  combinational read of `addr`:
  - 0 = count[7:0]
  - 1 = count[WIDTH-1:8], zero-extended
  - 2 = PRESC
  - 3 = {4'b0, pending, irq_en, periodic, enable}
- `s_finish_interr`  in  1  interrupt acknowledge pulse from the control unit.
- `i_timer`  out  1  interrupt request, level: `pending & irq_en`.

## Operation
- CTRL bits:
  - bit0 = `enable`
  - bit1 = `periodic`
  - bit2 = `irq_en`
  - bit3 on write = software clear of `pending`
  - all other bits ignored.
- FSM has two states, IDLE and RUN.
  - IDLE → RUN: on a CTRL write with bit0=1. In that cycle: `count` ← reload, prescaler counter ← 0.
  - RUN → IDLE: on a CTRL write with bit0=0. `count` holds its value.
  - RUN → IDLE: on expiry in one-shot mode. `enable` clears and `count` stays 0.
  - CTRL write with bit0=1 while in RUN: updates `periodic`/`irq_en` only; no reload, no prescaler restart.
- Prescaler runs only in RUN.
  - Counter `pc` counts 0..PRESC.
  - When `pc == PRESC`, a one-cycle `tick` is produced and `pc` ← 0.
  - PRESC=0 gives a tick every cycle.
- Main counter, evaluated on each `tick`:
  - If `count == 0`, this is an expiry: `pending` ← 1. In periodic mode `count` ← reload; in one-shot mode go to IDLE.
  - Otherwise `count` ← `count − 1`. No underflow wrap is possible.
- Period in cycles = (reload+1)·(PRESC+1).
- Reload value = {RELOAD_HI, RELOAD_LO}, truncated to WIDTH bits. Writes to it while in RUN take effect at the next reload only.
- `pending` is set by expiry. It is cleared by `s_finish_interr` or by a CTRL write with bit3=1.
- If expiry and a clear occur in the same cycle, `pending` stays 1: the new event wins.
- Clearing `irq_en` masks `i_timer` but keeps `pending`. Setting `irq_en` again re-asserts `i_timer` when `pending`=1.
- Acknowledge while `pending`=0 has no effect.

## Timing
- Reset values: all registers 0, FSM in IDLE, `i_timer`=0, `rdata` reflects the zeroed registers.
- A register write takes effect on the `clk` edge where `we`=1. `rdata` shows the new value in the following cycle.
- Starting from a CTRL enable write at edge E0:
  - the first `tick` occurs at edge E0+PRESC+1;
  - with reload=R, expiry occurs at tick R+1.
  - `pending` and `i_timer` go high one edge after the expiring tick edge, i.e. registered with no extra latency beyond the state update.
- `s_finish_interr` sampled at edge E drops `i_timer` after edge E.
- `reset` asserted mid-count: the next edge returns everything to reset values, regardless of `we` in the same cycle; reset has priority.

## Structure
- Shared package `timer_pkg` holds:
  - address constants `A_RELOAD_LO`, `A_RELOAD_HI`, `A_PRESC`, `A_CTRL`;
  - CTRL bit indices `B_EN`, `B_PER`, `B_IE`, `B_CLR`;
  - state enum `{IDLE, RUN}`.
- Sub-module `tick_gen` (parameter PW): inputs `clk`, `reset`, `run`, `presc`; output one-cycle `tick`. Deasserting `run` zeroes its counter.
- Top-level holds the register file, FSM, main counter, pending flag and read mux.

## Test plan
- One-shot: RELOAD=0x0003, PRESC=0, CTRL=0x05 → `i_timer` rises exactly 4 cycles after the CTRL write edge. Then `enable` reads 0 and `count` reads 0.
- Periodic with prescale: RELOAD=0x0001, PRESC=2, CTRL=0x07, ack each request → `i_timer` rises every 6 cycles across 5 periods.
- Simultaneous expiry and ack: periodic RELOAD=0, PRESC=0, pulse `s_finish_interr` every cycle → `i_timer` stays 1.
- Masking: expiry with `irq_en`=0 → `i_timer`=0 and CTRL reads bit3=1. Write CTRL=0x05 → `i_timer`=1 on the next cycle.
- Mid-run reload write: periodic RELOAD=10, write RELOAD_LO=2 during count 6 → current period still ends at 11 ticks, subsequent periods are 3 ticks.
- Reset mid-count with `we`=1 in the same cycle → all `rdata` values read 0, `i_timer`=0, no expiry occurs afterwards.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the interval timer: register map, CTRL bit positions
// and the run-state encoding.
package timer_pkg;

    localparam logic [1:0] A_RELOAD_LO = 2'd0;
    localparam logic [1:0] A_RELOAD_HI = 2'd1;
    localparam logic [1:0] A_PRESC     = 2'd2;
    localparam logic [1:0] A_CTRL      = 2'd3;

    localparam int B_EN  = 0;
    localparam int B_PER = 1;
    localparam int B_IE  = 2;
    localparam int B_CLR = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Clock prescaler: emits a one-cycle tick every (presc+1) cycles while run is high.
module tick_gen #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [PW-1:0] presc,
    output logic          tick
);

    logic [PW-1:0] pc_r;

    // >= rather than == so a smaller PRESC written mid-run cannot stall for a full wrap
    assign tick = run && (pc_r >= presc);

    // Prescale counter; held at zero whenever the timer is not running
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= {PW{1'b0}};
        end else if (!run) begin
            pc_r <= {PW{1'b0}};
        end else if (tick) begin
            pc_r <= {PW{1'b0}};
        end else begin
            pc_r <= pc_r + PW'(1);
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer raising a level interrupt request that is
// held until acknowledged by the CPU or cleared through CTRL.
module interval_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PW    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       s_finish_interr,
    output logic       i_timer
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        reload_lo_r;
    logic [7:0]        reload_hi_r;
    logic [PW-1:0]     presc_r;
    logic              periodic_r;
    logic              irq_en_r;
    logic              pending_r;
    logic              i_timer_r;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  count_nxt_s;
    logic              irq_en_nxt_s;
    logic              pending_nxt_s;
    logic              expire_s;
    logic              ctrl_wr_s;
    logic              clear_s;
    logic              tick_s;
    logic              run_s;
    logic [15:0]       reload_full_s;
    logic [WIDTH-1:0]  reload_s;
    logic [15:0]       count_ext_s;

    assign ctrl_wr_s     = we && (addr == A_CTRL);
    assign clear_s       = s_finish_interr || (ctrl_wr_s && wdata[B_CLR]);
    assign run_s         = (state_r == RUN);
    assign reload_full_s = {reload_hi_r, reload_lo_r};
    assign reload_s      = reload_full_s[WIDTH-1:0];
    assign count_ext_s   = 16'(count_r);
    assign i_timer       = i_timer_r;

    tick_gen #(
        .PW(PW)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .run  (run_s),
        .presc(presc_r),
        .tick (tick_s)
    );

    // Next-state logic for the run FSM, main counter and pending flag
    always_comb begin
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        expire_s      = 1'b0;
        irq_en_nxt_s  = irq_en_r;
        pending_nxt_s = pending_r;
        case (state_r)
            IDLE: begin
                if (ctrl_wr_s && wdata[B_EN]) begin
                    state_nxt_s = RUN;
                    count_nxt_s = reload_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                // An explicit stop wins over a tick in the same cycle; count is frozen
                if (ctrl_wr_s && !wdata[B_EN]) begin
                    state_nxt_s = IDLE;
                end else if (tick_s) begin
                    if (count_r == {WIDTH{1'b0}}) begin
                        expire_s = 1'b1;
                        if (periodic_r) begin
                            count_nxt_s = reload_s;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        count_nxt_s = count_r - WIDTH'(1);
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (ctrl_wr_s) begin
            irq_en_nxt_s = wdata[B_IE];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
        if (expire_s) begin
            pending_nxt_s = 1'b1;
        end else if (clear_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Register file, FSM state, counter and the registered interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            reload_lo_r <= 8'h00;
            reload_hi_r <= 8'h00;
            presc_r     <= {PW{1'b0}};
            periodic_r  <= 1'b0;
            irq_en_r    <= 1'b0;
            pending_r   <= 1'b0;
            i_timer_r   <= 1'b0;
            count_r     <= {WIDTH{1'b0}};
        end else begin
            if (we && (addr == A_RELOAD_LO)) begin
                reload_lo_r <= wdata;
            end
            if (we && (addr == A_RELOAD_HI)) begin
                reload_hi_r <= wdata;
            end
            if (we && (addr == A_PRESC)) begin
                presc_r <= PW'(wdata);
            end
            if (ctrl_wr_s) begin
                periodic_r <= wdata[B_PER];
            end
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            irq_en_r  <= irq_en_nxt_s;
            pending_r <= pending_nxt_s;
            i_timer_r <= pending_nxt_s & irq_en_nxt_s;
        end
    end

    // Register read mux
    always_comb begin
        rdata = 8'h00;
        case (addr)
            A_RELOAD_LO: rdata = count_ext_s[7:0];
            A_RELOAD_HI: rdata = count_ext_s[15:8];
            A_PRESC:     rdata = 8'(presc_r);
            A_CTRL:      rdata = {4'b0000, pending_r, irq_en_r, periodic_r, run_s};
            default:     rdata = 8'h00;
        endcase
    end

endmodule
